regfile_access_ctrl: RTL and testbench

//   Initiator side of the Registers bank port protocol: read ports A/B (en/addr/data) and write port C (en/addr/data).

---
 rtl/regfile_access_ctrl_pkg.sv | 17 +
 rtl/regfile_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-bank access controller: FSM encoding,
// default widths and the hardwired-zero register address.
package regfile_access_ctrl_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_READ     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_WRITE    = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Sequences one decoded instruction through the register bank: operand read on
// ports A/B, hand-off to execute, then result writeback on port C.
//
//   state       | meaning
//   ST_IDLE     | ready for a new instruction
//   ST_READ     | ports A/B enabled, operands captured at the end of the cycle
//   ST_ISSUE    | operands presented to execute, waiting for op_ready
//   ST_WAIT_RES | waiting for the execute result
//   ST_WRITE    | single-cycle port C commit of the result
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit WRITE_R0 = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic              instr_wb,
  output logic              ena,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dataa,
  output logic              enb,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] datab,
  output logic              enc,
  output logic [ADDR_W-1:0] addrc,
  output logic [DATA_W-1:0] datac,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] rd_q, rd_nxt;
  logic              wb_q, wb_nxt;
  logic              ena_nxt, enb_nxt, enc_nxt, op_valid_nxt;
  logic [ADDR_W-1:0] addra_nxt, addrb_nxt, addrc_nxt;
  logic [DATA_W-1:0] datac_nxt, op_a_nxt, op_b_nxt;
  logic              wr_allowed;

  assign instr_ready = (state == ST_IDLE) && !reset;
  assign busy        = (state != ST_IDLE);
  assign wr_allowed  = WRITE_R0 || (rd_q != ADDR_W'(REG_ZERO));

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      ena      <= 1'b0;
      enb      <= 1'b0;
      enc      <= 1'b0;
      addra    <= '0;
      addrb    <= '0;
      addrc    <= '0;
      datac    <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      state    <= state_nxt;
      rd_q     <= rd_nxt;
      wb_q     <= wb_nxt;
      ena      <= ena_nxt;
      enb      <= enb_nxt;
      enc      <= enc_nxt;
      addra    <= addra_nxt;
      addrb    <= addrb_nxt;
      addrc    <= addrc_nxt;
      datac    <= datac_nxt;
      op_valid <= op_valid_nxt;
      op_a     <= op_a_nxt;
      op_b     <= op_b_nxt;
    end
  end

  // Port enables default low so every enable is a single-cycle pulse.
  always_comb begin
    state_nxt    = state;
    rd_nxt       = rd_q;
    wb_nxt       = wb_q;
    ena_nxt      = 1'b0;
    enb_nxt      = 1'b0;
    enc_nxt      = 1'b0;
    addra_nxt    = addra;
    addrb_nxt    = addrb;
    addrc_nxt    = addrc;
    datac_nxt    = datac;
    op_valid_nxt = op_valid;
    op_a_nxt     = op_a;
    op_b_nxt     = op_b;
    unique case (state)
      ST_IDLE: begin
        if (instr_valid && instr_ready) begin
          rd_nxt    = instr_rd;
          wb_nxt    = instr_wb;
          addra_nxt = instr_rs;
          addrb_nxt = instr_rt;
          ena_nxt   = 1'b1;
          enb_nxt   = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        op_a_nxt     = dataa;
        op_b_nxt     = datab;
        op_valid_nxt = 1'b1;
        state_nxt    = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (op_ready) begin
          op_valid_nxt = 1'b0;
          state_nxt    = wb_q ? ST_WAIT_RES : ST_IDLE;
        end
      end
      ST_WAIT_RES: begin
        if (res_valid) begin
          addrc_nxt = rd_q;
          datac_nxt = res_data;
          enc_nxt   = wr_allowed;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomized scoreboard bench for regfile_access_ctrl against a behavioural
// register bank and a reference register-file model.
module tb_regfile_access_ctrl;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  logic          clock, reset;
  logic          instr_valid, instr_ready, instr_wb;
  logic [AW-1:0] instr_rs, instr_rt, instr_rd;
  logic          ena, enb, enc;
  logic [AW-1:0] addra, addrb, addrc;
  logic [DW-1:0] dataa, datab, datac;
  logic          op_valid, op_ready;
  logic [DW-1:0] op_a, op_b;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          load_bank;

  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] bank    [32];
  op_exp_t       op_q [$];
  wr_exp_t       wr_q [$];
  int            checks   = 0;
  int            failures = 0;
  int            wr_expected = 0;
  int            wr_seen     = 0;

  regfile_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WRITE_R0(1'b0)) dut (
    .clock(clock), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_rs(instr_rs), .instr_rt(instr_rt), .instr_rd(instr_rd), .instr_wb(instr_wb),
    .ena(ena), .addra(addra), .dataa(dataa),
    .enb(enb), .addrb(addrb), .datab(datab),
    .enc(enc), .addrc(addrc), .datac(datac),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank: combinational read while enabled, write on the clock edge.
  assign dataa = ena ? bank[addra] : '0;
  assign datab = enb ? bank[addrb] : '0;
  always @(posedge clock) begin
    if (load_bank) begin
      for (int i = 0; i < 32; i++) bank[i] <= ref_mem[i];
    end else if (enc) begin
      bank[addrc] <= datac;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor samples just before each rising edge, where the DUT sees the same values.
  initial begin
    op_exp_t oe;
    wr_exp_t we;
    forever begin
      @(negedge clock);
      #4;
      if (op_valid && op_ready) begin
        if (op_q.size() == 0) begin
          chk("op_unexpected", 64'd1, 64'd0);
        end else begin
          oe = op_q.pop_front();
          chk("op_a", op_a, oe.a);
          chk("op_b", op_b, oe.b);
        end
      end
      if (enc) begin
        wr_seen++;
        chk("enc_excl_ab", {ena, enb}, 2'b00);
        if (wr_q.size() == 0) begin
          chk("wr_unexpected", {addrc, datac}, 64'd0);
        end else begin
          we = wr_q.pop_front();
          chk("wr_addr", addrc, we.addr);
          chk("wr_data", datac, we.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic run_instr(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                           input logic [AW-1:0] rd, input logic wb,
                           input logic [DW-1:0] res, input int stall,
                           input int res_wait, input bit abort);
    op_exp_t oe;
    wr_exp_t we;
    int      n;
    oe.a = ref_mem[rs];
    oe.b = ref_mem[rt];
    op_q.push_back(oe);
    if (wb && rd != 0 && !abort) begin
      we.addr = rd;
      we.data = res;
      wr_q.push_back(we);
      ref_mem[rd] = res;
      wr_expected++;
    end
    @(negedge clock);
    instr_valid = 1'b1;
    instr_rs = rs; instr_rt = rt; instr_rd = rd; instr_wb = wb;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("accept", instr_ready, 1);
    @(negedge clock);
    instr_valid = 1'b0;
    instr_rs = AW'($urandom); instr_rt = AW'($urandom);
    instr_rd = AW'($urandom); instr_wb = 1'($urandom);
    chk("read_ctl", {ena, enb, op_valid, busy, instr_ready}, 5'b11010);
    chk("read_addr", {addra, addrb}, {rs, rt});
    @(negedge clock);
    chk("issue_ctl", {ena, enb, op_valid, enc, busy}, 5'b00101);
    for (int i = 0; i < stall; i++) begin
      chk("stall_ops", {op_a, op_b}, {oe.a, oe.b});
      chk("stall_ctl", {op_valid, instr_ready, enc, ena, enb}, 5'b10000);
      @(negedge clock);
    end
    op_ready = 1'b1;
    @(negedge clock);
    op_ready = 1'b0;
    chk("post_hs", {op_valid, busy}, {1'b0, wb});
    if (wb) begin
      if (abort) begin
        reset = 1'b1;
        res_valid = 1'b1;
        res_data = res;
        @(negedge clock);
        res_valid = 1'b0;
        chk("abort_state", {enc, busy, instr_ready, op_valid}, 4'b0000);
        reset = 1'b0;
        #1;
      end else begin
        for (int i = 0; i < res_wait; i++) begin
          chk("wait_res", {enc, busy, instr_ready}, 3'b010);
          @(negedge clock);
        end
        res_valid = 1'b1;
        res_data = res;
        @(negedge clock);
        res_valid = 1'b0;
        res_data = $urandom;
        chk("write_cyc", {busy, instr_ready, ena, enb}, 4'b1000);
        @(negedge clock);
      end
    end
    chk("idle", {busy, instr_ready, enc}, 3'b010);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = $urandom;
    ref_mem[0] = '0;
    reset = 1'b1; load_bank = 1'b1;
    instr_valid = 1'b0; instr_rs = '0; instr_rt = '0; instr_rd = '0; instr_wb = 1'b0;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;

    repeat (2) @(negedge clock);
    chk("rst_en", {ena, enb, enc, op_valid, instr_ready, busy}, 6'b0);
    chk("rst_addr", {addra, addrb, addrc}, 15'd0);
    chk("rst_datac", datac, 0);
    chk("rst_ops", {op_a, op_b}, 64'd0);
    reset = 1'b0; load_bank = 1'b0;
    #1;
    chk("rel_ready", {instr_ready, busy}, 2'b10);

    run_instr(5'd3, 5'd4, 5'd11, 1'b1, 32'd45, 0, 0, 1'b0);
    run_instr(5'd7, 5'd9, 5'd12, 1'b1, 32'd75, 0, 0, 1'b0);
    run_instr(5'd11, 5'd12, 5'd20, 1'b0, 32'd0, 0, 0, 1'b0);
    run_instr(5'd11, 5'd12, 5'd21, 1'b0, 32'd0, 5, 0, 1'b0);
    run_instr(5'd1, 5'd2, 5'd0, 1'b1, 32'd99, 0, 0, 1'b0);

    @(negedge clock);
    res_valid = 1'b1; res_data = 32'd123;
    @(negedge clock);
    res_valid = 1'b0;
    chk("res_in_idle", {busy, enc, instr_ready}, 3'b001);
    @(negedge clock);
    chk("res_in_idle2", {busy, enc}, 2'b00);

    run_instr(5'd11, 5'd12, 5'd13, 1'b1, 32'd555, 0, 0, 1'b1);
    run_instr(5'd11, 5'd12, 5'd13, 1'b0, 32'd0, 0, 0, 1'b0);
    chk("r11_r12_kept", {ref_mem[11], ref_mem[12]}, {32'd45, 32'd75});

    for (int k = 0; k < 40; k++) begin
      run_instr(AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clock);
    chk("op_q_drained", op_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    chk("wr_count", wr_seen, wr_expected);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
